// File: rtl/rs_multi_issue_select_pkg.sv
// Shared sizing and types for the reservation-station select stage.
package rs_multi_issue_select_pkg;

    localparam int RS_ENTRIES  = 16;
    localparam int ISSUE_WIDTH = 2;
    localparam int RS_IDX_W    = $clog2(RS_ENTRIES);

    typedef logic [RS_IDX_W-1:0]    rs_idx_t;
    typedef logic [RS_ENTRIES-1:0]  rs_mask_t;
    typedef logic [ISSUE_WIDTH-1:0] rs_port_t;

    function automatic rs_mask_t rs_onehot(input rs_idx_t idx);
        rs_mask_t m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix for oldest-first select. older[i][j]=1 means entry i is older
// than entry j. Also answers the per-port oldest-of-candidates chain so the
// top only has to hand over the eligible mask and port readiness.
module rs_age_matrix
    import rs_multi_issue_select_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       alloc_en,
    input  rs_idx_t                    alloc_idx,
    input  rs_mask_t                   cand,
    input  rs_port_t                   port_ready,
    output rs_port_t                   sel_vld,
    output rs_idx_t [ISSUE_WIDTH-1:0]  sel_idx
);

    rs_mask_t [RS_ENTRIES-1:0] older;
    rs_mask_t [RS_ENTRIES-1:0] older_nxt;
    rs_mask_t                  rem;

    // New allocation becomes youngest: every other entry is older than it,
    // and it is older than nobody. Rows of free entries are stale but never
    // consulted, and get cleared on their own allocation.
    always_comb begin
        older_nxt = older;
        if (alloc_en) begin
            for (int j = 0; j < RS_ENTRIES; j++)
                older_nxt[j][alloc_idx] = 1'b1;
            older_nxt[alloc_idx] = '0;
        end
    end

    // Matrix register, cleared by reset or flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        older <= '0;
        else if (flush) older <= '0;
        else            older <= older_nxt;
    end

    // Ports in order: a ready port takes the candidate no other candidate
    // is older than, then removes it from the pool for later ports.
    always_comb begin
        logic blocked;
        rem     = cand;
        sel_vld = '0;
        sel_idx = '0;
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            if (port_ready[p]) begin
                for (int i = 0; i < RS_ENTRIES; i++) begin
                    blocked = 1'b0;
                    for (int j = 0; j < RS_ENTRIES; j++)
                        blocked = blocked | (rem[j] & older[j][i]);
                    if (rem[i] && !blocked && !sel_vld[p]) begin
                        sel_vld[p] = 1'b1;
                        sel_idx[p] = rs_idx_t'(i);
                    end
                end
                if (sel_vld[p]) rem[sel_idx[p]] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rs_multi_issue_select.sv
// Multi-issue select: each cycle picks up to ISSUE_WIDTH eligible entries
// and registers one grant per ready port. Tracks valid/in-flight entries.
// Build option RS_AGE_SELECT_EN: oldest-first via rs_age_matrix; without it
// priority is fixed, lowest index first.
module rs_multi_issue_select
    import rs_multi_issue_select_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            alloc_en,
    input  logic [RS_IDX_W-1:0]             alloc_idx,
    input  logic [RS_ENTRIES-1:0]           dealloc_mask,
    input  logic [RS_ENTRIES-1:0]           request_vector,
    input  logic [ISSUE_WIDTH-1:0]          port_ready,
    output logic [ISSUE_WIDTH-1:0]          grant_en,
    output logic [ISSUE_WIDTH*RS_IDX_W-1:0] grant_index,
    output logic [RS_ENTRIES-1:0]           inflight_mask
);

    rs_mask_t                  valid;
    rs_mask_t                  inflight;
    rs_mask_t                  cand;
    rs_mask_t                  gnt_mask;
    rs_mask_t                  alloc_oh;
    rs_port_t                  sel_vld;
    rs_idx_t [ISSUE_WIDTH-1:0] sel_idx;
    rs_idx_t [ISSUE_WIDTH-1:0] gidx_q;

    assign cand          = request_vector & valid & ~inflight;
    assign alloc_oh      = alloc_en ? rs_onehot(alloc_idx) : '0;
    assign inflight_mask = inflight;
    assign grant_index   = gidx_q;

`ifdef RS_AGE_SELECT_EN
    rs_age_matrix u_age (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .alloc_en   (alloc_en),
        .alloc_idx  (alloc_idx),
        .cand       (cand),
        .port_ready (port_ready),
        .sel_vld    (sel_vld),
        .sel_idx    (sel_idx)
    );
`else
    rs_mask_t rem;

    // Fixed priority: each ready port takes the lowest remaining index
    always_comb begin
        rem     = cand;
        sel_vld = '0;
        sel_idx = '0;
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            if (port_ready[p]) begin
                for (int i = 0; i < RS_ENTRIES; i++) begin
                    if (rem[i] && !sel_vld[p]) begin
                        sel_vld[p] = 1'b1;
                        sel_idx[p] = rs_idx_t'(i);
                    end
                end
                if (sel_vld[p]) rem[sel_idx[p]] = 1'b0;
            end
        end
    end
`endif

    // Entries picked this cycle, to be marked in-flight
    always_comb begin
        gnt_mask = '0;
        for (int p = 0; p < ISSUE_WIDTH; p++)
            if (sel_vld[p]) gnt_mask[sel_idx[p]] = 1'b1;
    end

    // Entry state: grants set in-flight, then dealloc, then alloc (so a
    // same-cycle dealloc+alloc leaves the entry valid and not in flight)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid    <= '0;
            inflight <= '0;
        end else if (flush) begin
            valid    <= '0;
            inflight <= '0;
        end else begin
            valid    <= (valid & ~dealloc_mask) | alloc_oh;
            inflight <= (inflight | gnt_mask) & ~dealloc_mask & ~alloc_oh;
        end
    end

    // Grant registers; an idle port keeps its last index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_en <= '0;
            gidx_q   <= '0;
        end else if (flush) begin
            grant_en <= '0;
            gidx_q   <= '0;
        end else begin
            grant_en <= sel_vld;
            for (int p = 0; p < ISSUE_WIDTH; p++)
                if (sel_vld[p]) gidx_q[p] <= sel_idx[p];
        end
    end

`ifndef SYNTHESIS
    // Dispatch must never re-allocate a live entry that is not freed this cycle
    always @(posedge clk) begin
        if (!rst && !flush && alloc_en)
            assert (!(valid[alloc_idx] && !dealloc_mask[alloc_idx]));
    end
`endif

endmodule

// File: tb/tb_rs_multi_issue_select.sv
// Bench for rs_multi_issue_select: directed scenarios plus random traffic,
// all checked against an allocation-timestamp reference model.
module tb_rs_multi_issue_select;
    import rs_multi_issue_select_pkg::*;

`ifdef RS_AGE_SELECT_EN
    localparam bit AGE = 1'b1;
`else
    localparam bit AGE = 1'b0;
`endif

    logic                            clk = 1'b0;
    logic                            rst;
    logic                            flush;
    logic                            alloc_en;
    logic [RS_IDX_W-1:0]             alloc_idx;
    logic [RS_ENTRIES-1:0]           dealloc_mask;
    logic [RS_ENTRIES-1:0]           request_vector;
    logic [ISSUE_WIDTH-1:0]          port_ready;
    logic [ISSUE_WIDTH-1:0]          grant_en;
    logic [ISSUE_WIDTH*RS_IDX_W-1:0] grant_index;
    logic [RS_ENTRIES-1:0]           inflight_mask;

    rs_multi_issue_select dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .alloc_en       (alloc_en),
        .alloc_idx      (alloc_idx),
        .dealloc_mask   (dealloc_mask),
        .request_vector (request_vector),
        .port_ready     (port_ready),
        .grant_en       (grant_en),
        .grant_index    (grant_index),
        .inflight_mask  (inflight_mask)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: per-entry flags plus an allocation timestamp
    bit          m_valid [RS_ENTRIES];
    bit          m_infl  [RS_ENTRIES];
    int unsigned m_stamp [RS_ENTRIES];
    int unsigned m_clock;
    int          pick    [ISSUE_WIDTH];
    bit          m_gen   [ISSUE_WIDTH];
    int          m_gidx  [ISSUE_WIDTH];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < RS_ENTRIES; i++) begin
            m_valid[i] = 0;
            m_infl[i]  = 0;
            m_stamp[i] = 0;
        end
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            m_gen[p]  = 0;
            m_gidx[p] = 0;
        end
    endtask

    // Decide this cycle's grants from the currently driven inputs
    task automatic model_pick();
        bit taken [RS_ENTRIES];
        for (int i = 0; i < RS_ENTRIES; i++) taken[i] = 0;
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            pick[p] = -1;
            if (port_ready[p]) begin
                for (int i = 0; i < RS_ENTRIES; i++) begin
                    if (request_vector[i] && m_valid[i] && !m_infl[i] && !taken[i]) begin
                        if (pick[p] < 0) pick[p] = i;
                        else if (AGE && m_stamp[i] < m_stamp[pick[p]]) pick[p] = i;
                    end
                end
            end
            if (pick[p] >= 0) taken[pick[p]] = 1;
        end
    endtask

    // Apply the clock edge to the model
    task automatic model_commit();
        if (flush) begin
            model_clear();
            return;
        end
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            m_gen[p] = (pick[p] >= 0);
            if (pick[p] >= 0) begin
                m_gidx[p]       = pick[p];
                m_infl[pick[p]] = 1;
            end
        end
        for (int i = 0; i < RS_ENTRIES; i++)
            if (dealloc_mask[i]) begin
                m_valid[i] = 0;
                m_infl[i]  = 0;
            end
        if (alloc_en) begin
            m_valid[alloc_idx] = 1;
            m_infl[alloc_idx]  = 0;
            m_stamp[alloc_idx] = m_clock++;
        end
    endtask

    task automatic check_model();
        logic [ISSUE_WIDTH-1:0]          eg;
        logic [ISSUE_WIDTH*RS_IDX_W-1:0] ei;
        logic [RS_ENTRIES-1:0]           em;
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            eg[p] = m_gen[p];
            ei[p*RS_IDX_W +: RS_IDX_W] = RS_IDX_W'(m_gidx[p]);
        end
        for (int i = 0; i < RS_ENTRIES; i++) em[i] = m_infl[i];
        chk("grant_en", 64'(grant_en), 64'(eg));
        chk("grant_index", 64'(grant_index), 64'(ei));
        chk("inflight_mask", 64'(inflight_mask), 64'(em));
    endtask

    task automatic step(input bit a_en, input int a_idx, input logic [RS_ENTRIES-1:0] dm,
                        input logic [RS_ENTRIES-1:0] req, input logic [ISSUE_WIDTH-1:0] pr,
                        input bit fl);
        alloc_en       = a_en;
        alloc_idx      = RS_IDX_W'(a_idx);
        dealloc_mask   = dm;
        request_vector = req;
        port_ready     = pr;
        flush          = fl;
        model_pick();
        @(posedge clk);
        #1;
        model_commit();
        check_model();
    endtask

    // Asynchronous reset mid-cycle: outputs must clear without a clock edge
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_grant_en", 64'(grant_en), 64'(0));
        chk("rst_grant_index", 64'(grant_index), 64'(0));
        chk("rst_inflight", 64'(inflight_mask), 64'(0));
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 0; alloc_en = 0; alloc_idx = '0;
        dealloc_mask = '0; request_vector = '0; port_ready = '0;
        m_clock = 0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        chk("reset_grant_en", 64'(grant_en), 64'(0));
        chk("reset_inflight", 64'(inflight_mask), 64'(0));
        rst = 1'b0;

        // Alloc 3, request 3: grant on port 0 two cycles after alloc
        step(1, 3, '0, '0, 2'b00, 0);
        step(0, 0, '0, 16'h0008, 2'b11, 0);
        chk("t1_grant_en", 64'(grant_en), 64'(2'b01));
        chk("t1_idx0", 64'(grant_index[RS_IDX_W-1:0]), 64'(3));
        do_reset();

        // Age ordering with entries 5, 2, 9
        step(1, 5, '0, '0, 2'b00, 0);
        step(1, 2, '0, '0, 2'b00, 0);
        step(1, 9, '0, '0, 2'b00, 0);
        step(0, 0, '0, 16'h0224, 2'b11, 0);
        chk("t2_grant_en", 64'(grant_en), 64'(2'b11));
        chk("t2_idx0", 64'(grant_index[RS_IDX_W-1:0]), 64'(AGE ? 5 : 2));
        chk("t2_idx1", 64'(grant_index[2*RS_IDX_W-1:RS_IDX_W]), 64'(AGE ? 2 : 5));
        step(0, 0, 16'h0024, 16'h0224, 2'b11, 0);
        chk("t2_idx0_9", 64'(grant_index[RS_IDX_W-1:0]), 64'(9));

        // Backpressure: only port 1 ready, eligible {1,4}, 4 older
        step(0, 0, '0, '0, 2'b00, 1);
        step(1, 4, '0, '0, 2'b00, 0);
        step(1, 1, '0, '0, 2'b00, 0);
        step(0, 0, '0, 16'h0012, 2'b10, 0);
        chk("t3_grant_en", 64'(grant_en), 64'(2'b10));
        chk("t3_idx1", 64'(grant_index[2*RS_IDX_W-1:RS_IDX_W]), 64'(AGE ? 4 : 1));

        // Same-cycle alloc+dealloc of in-flight 7; then no re-grant while in flight
        step(0, 0, '0, '0, 2'b00, 1);
        step(1, 6, '0, '0, 2'b00, 0);
        step(1, 7, '0, '0, 2'b00, 0);
        step(0, 0, '0, 16'h0080, 2'b01, 0);
        step(1, 7, 16'h0080, '0, 2'b00, 0);
        chk("t5_infl7", 64'(inflight_mask[7]), 64'(0));
        step(0, 0, '0, 16'h00c0, 2'b01, 0);
        chk("t5_idx0", 64'(grant_index[RS_IDX_W-1:0]), 64'(6));
        step(0, 0, '0, 16'h00c0, 2'b01, 0);
        chk("t4_idx0", 64'(grant_index[RS_IDX_W-1:0]), 64'(7));
        step(0, 0, '0, 16'h00c0, 2'b11, 0);
        chk("t4_no_regrant", 64'(grant_en), 64'(0));

        // Flush with 4 valid, 2 in flight
        step(0, 0, '0, '0, 2'b00, 1);
        for (int k = 0; k < 4; k++) step(1, k, '0, '0, 2'b00, 0);
        step(0, 0, '0, 16'h0003, 2'b11, 0);
        step(0, 0, '0, 16'h000f, 2'b11, 1);
        chk("t6_grant_en", 64'(grant_en), 64'(0));
        chk("t6_inflight", 64'(inflight_mask), 64'(0));
        step(0, 0, '0, 16'h000f, 2'b11, 0);
        chk("t6_ignored", 64'(grant_en), 64'(0));

        // Random traffic: legal allocs, deallocs only of in-flight entries
        for (int n = 0; n < 1500; n++) begin
            logic [RS_ENTRIES-1:0] d;
            int                    k;
            bit                    a;
            d = '0;
            for (int i = 0; i < RS_ENTRIES; i++)
                if (m_infl[i] && $urandom_range(2) == 0) d[i] = 1'b1;
            k = int'($urandom_range(RS_ENTRIES-1));
            a = ($urandom_range(9) < 6) && (!m_valid[k] || d[k]);
            step(a, k, d, RS_ENTRIES'($urandom), ISSUE_WIDTH'($urandom),
                 $urandom_range(49) == 0);
            if (n == 700) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
